jt9346_host: RTL and testbench
==============================

# jt9346_host

Microwire host controller for 93C46-style serial EEPROMs with the JTEEPROM 9346 serial pinout (sclk/sdi/sdo/scs). It turns single-cycle command requests from a core into serial frames, collects read data, and polls the ready/busy status after programming commands. It sits between a core's NVRAM logic and the EEPROM, and doubles as the bench driver for jt9346.

## Interface
- AW, 6: EEPROM address width.
- DW, 16: EEPROM data width.
- CLKDIV, 4: clk cycles per sclk half-period; legal values ≥2.
- POLL_MAX, 4096: clk cycles allowed for the ready poll before error.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  command strobe, sampled only when busy=0.
- cmd  in  3  0 READ, 1 WRITE, 2 ERASE, 3 EWEN, 4 EWDS, 5 ERAL, 6 WRAL; 7 is treated as EWDS.
- addr  in  AW  word address (READ/WRITE/ERASE).
- din  in  DW  write data (WRITE/WRAL).
- busy  out  1  high from the cycle after an accepted req through the done cycle.
- done  out  1  one-cycle pulse at command end.
- err  out  1  valid with done: poll timeout.
- dout  out  DW  read data, valid from done until the next accepted READ.
- sclk  out  1  serial clock to EEPROM.
- scs  out  1  chip select, active high.
- sdi  out  1  serial data to EEPROM.
- sdo  in  1  serial data and ready from EEPROM.

## Operation
- Frame, MSB first: start bit 1, 2-bit opcode, AW-bit field, then optional DW data bits. Header length is 3+AW bits.
- Opcodes: READ 10, WRITE 01, ERASE 11, and 00 for the rest. For 00 commands, the field's top 2 bits select the command and the rest are 0: EWEN 11, EWDS 00, ERAL 10, WRAL 01.
- Payload per command:
  - READ: DW read clocks follow the header.
  - WRITE and WRAL: DW bits of din follow the header.
  - Other commands have no payload.
- States: IDLE → SEL → SHIFT → (RDATA | WDATA) → DESEL → [POLL → DESEL2] → FIN → IDLE.
- IDLE: all outputs low except held dout/err. On req, latch cmd/addr/din, assert busy, go to SEL.
- SEL: scs=1, sclk=0, sdi=start bit, for CLKDIV cycles.
- SHIFT and WDATA: each bit is sclk high for CLKDIV cycles, then low for CLKDIV cycles. sdi changes only on the clk edge where sclk falls (or at SEL entry), so it is stable across the whole high phase.
- RDATA: sdi=0 for DW clocks. sdo is sampled on the clk where sclk goes high→low and shifted into the LSB of a shift register. The first sample is data MSB.
- DESEL: scs=0, sclk=0 for CLKDIV cycles.
- POLL (WRITE, ERASE, ERAL, WRAL only):
  - scs=1; sdo is ignored for the first 2 cycles, then sampled each clk.
  - sdo=1 → DESEL2 (scs=0 for CLKDIV cycles) → FIN.
  - POLL_MAX cycles without sdo=1 → err=1 → DESEL2.
- Commands without POLL go DESEL → FIN.
- FIN: done=1 for one cycle, busy=0 on the next cycle. dout updates here for READ only. err is cleared at each accepted req.
- req while busy=1 is ignored; no queue.
- Reset mid-frame: sclk, scs, sdi, busy and done drop immediately. dout=0, err=0, state IDLE. The EEPROM sees scs low and aborts.

## Timing
- Bit period 2·CLKDIV clk cycles.
- Command latency from req, with H=3+AW:
  - READ: 1 + CLKDIV + (H+DW)·2·CLKDIV + CLKDIV + 1 cycles to done. For AW=6, DW=16, CLKDIV=4: 1+4+200+4+1 = 210.
  - EWEN: 1 + CLKDIV + H·2·CLKDIV + CLKDIV + 1 = 82 with defaults.
  - Polled commands: add the poll time + CLKDIV.
- sdo sample point is CLKDIV−1 cycles after the rising edge. This tolerates EEPROM output delay up to CLKDIV−1 clk.

## Test plan
- EWEN, defaults, against the jt9346 model: the sdi bits latched at sclk rises are 1,0,0,1,1,0,0,0,0; done at cycle 82; err=0.
- EWEN, then WRITE addr 0x15 din 0xA5C3, then READ 0x15: dout=0xA5C3, err=0. Frame bit 0 of the WRITE payload equals din[15]. The poll ends with sdo=1.
- ERASE 0x15 after EWEN, then READ 0x15: dout=0xFFFF. Next, WRAL 0x1234: reads of 0x00 and 0x3F return 0x1234.
- sdo tied 0, WRITE: done after exactly POLL_MAX poll cycles with err=1 and scs low. The next EWEN clears err.
- Assert rst during the 5th header bit of a READ: sclk=scs=sdi=busy=0 within the rst cycle. A following READ returns correct data.
- req pulsed while busy, and req held high: only one frame is issued per idle acceptance; a held req starts the next command the cycle after busy falls.

Source files
------------

// File: rtl/jt9346_host.sv
// Microwire host for 93C46-style serial EEPROMs: turns one-cycle command requests
// into start/opcode/address(/data) frames, collects read data and polls ready/busy.
module jt9346_host #(
  parameter int AW       = 6,
  parameter int DW       = 16,
  parameter int CLKDIV   = 4,
  parameter int POLL_MAX = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [2:0]    cmd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] dout,
  output logic          sclk,
  output logic          scs,
  output logic          sdi,
  input  logic          sdo
);

  localparam int HL   = 3 + AW;
  localparam int FL   = HL + DW;
  localparam int CMAX = (POLL_MAX > CLKDIV) ? POLL_MAX : CLKDIV;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(FL + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_MAX - 1);
  localparam logic [CW-1:0] POLL_SKIP = CW'(2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [BW-1:0] HDR_LAST  = BW'(HL - 1);
  localparam logic [BW-1:0] DAT_LAST  = BW'(DW - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);

  localparam logic [2:0] C_READ  = 3'd0;
  localparam logic [2:0] C_WRITE = 3'd1;
  localparam logic [2:0] C_ERASE = 3'd2;
  localparam logic [2:0] C_EWEN  = 3'd3;
  localparam logic [2:0] C_ERAL  = 3'd5;
  localparam logic [2:0] C_WRAL  = 3'd6;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SEL    = 4'd1,
    ST_SHIFT  = 4'd2,
    ST_RDATA  = 4'd3,
    ST_WDATA  = 4'd4,
    ST_DESEL  = 4'd5,
    ST_POLL   = 4'd6,
    ST_DESEL2 = 4'd7,
    ST_FIN    = 4'd8
  } state_t;

  // Start bit, opcode and address field; 00-opcode commands encode in the field's top bits.
  function automatic logic [HL-1:0] frame_hdr(input logic [2:0] c, input logic [AW-1:0] a);
    case (c)
      C_READ:  frame_hdr = {3'b110, a};
      C_WRITE: frame_hdr = {3'b101, a};
      C_ERASE: frame_hdr = {3'b111, a};
      C_EWEN:  frame_hdr = {3'b100, 2'b11, {(AW-2){1'b0}}};
      C_ERAL:  frame_hdr = {3'b100, 2'b10, {(AW-2){1'b0}}};
      C_WRAL:  frame_hdr = {3'b100, 2'b01, {(AW-2){1'b0}}};
      default: frame_hdr = {3'b100, 2'b00, {(AW-2){1'b0}}};
    endcase
  endfunction

  function automatic logic has_payload(input logic [2:0] c);
    has_payload = (c == C_WRITE) || (c == C_WRAL);
  endfunction

  function automatic logic needs_poll(input logic [2:0] c);
    needs_poll = (c == C_WRITE) || (c == C_ERASE) || (c == C_ERAL) || (c == C_WRAL);
  endfunction

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [BW-1:0]   bit_r;
  logic            ph_r;
  logic            rd_r;
  logic            wr_r;
  logic            poll_r;
  logic [FL-1:0]   tx_r;
  logic [DW-1:0]   rx_r;
  logic            last_bit_s;
  logic            next_sdi_s;

  // Last-bit detect and the data bit presented at the next sclk fall.
  always_comb begin
    last_bit_s = 1'b0;
    next_sdi_s = 1'b0;
    if (state_r == ST_SHIFT) begin
      last_bit_s = (bit_r == HDR_LAST);
    end else begin
      last_bit_s = (bit_r == DAT_LAST);
    end
    if (state_r == ST_RDATA) begin
      next_sdi_s = 1'b0;
    end else if (last_bit_s && !((state_r == ST_SHIFT) && wr_r)) begin
      next_sdi_s = 1'b0;
    end else begin
      next_sdi_s = tx_r[FL-2];
    end
  end

  // Command sequencer with registered serial pins and handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      bit_r   <= {BW{1'b0}};
      ph_r    <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      poll_r  <= 1'b0;
      tx_r    <= {FL{1'b0}};
      rx_r    <= {DW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      dout    <= {DW{1'b0}};
      sclk    <= 1'b0;
      scs     <= 1'b0;
      sdi     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          sclk <= 1'b0;
          scs  <= 1'b0;
          sdi  <= 1'b0;
          if (req) begin
            tx_r    <= {frame_hdr(cmd, addr), din};
            rd_r    <= (cmd == C_READ);
            wr_r    <= has_payload(cmd);
            poll_r  <= needs_poll(cmd);
            busy    <= 1'b1;
            err     <= 1'b0;
            scs     <= 1'b1;
            sdi     <= 1'b1;
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r   <= {CW{1'b0}};
            bit_r   <= {BW{1'b0}};
            ph_r    <= 1'b1;
            sclk    <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SHIFT, ST_RDATA, ST_WDATA: begin
          if (cnt_r != DIV_LAST) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else if (ph_r) begin
            // sclk falls: sample read data and move sdi to the next bit
            cnt_r <= {CW{1'b0}};
            ph_r  <= 1'b0;
            sclk  <= 1'b0;
            tx_r  <= {tx_r[FL-2:0], 1'b0};
            sdi   <= next_sdi_s;
            if (state_r == ST_RDATA) begin
              rx_r <= {rx_r[DW-2:0], sdo};
            end
          end else begin
            cnt_r <= {CW{1'b0}};
            if (!last_bit_s) begin
              bit_r <= bit_r + BIT_ONE;
              ph_r  <= 1'b1;
              sclk  <= 1'b1;
            end else if ((state_r == ST_SHIFT) && (rd_r || wr_r)) begin
              bit_r   <= {BW{1'b0}};
              ph_r    <= 1'b1;
              sclk    <= 1'b1;
              state_r <= rd_r ? ST_RDATA : ST_WDATA;
            end else begin
              scs     <= 1'b0;
              sdi     <= 1'b0;
              state_r <= ST_DESEL;
            end
          end
        end
        ST_DESEL: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r <= {CW{1'b0}};
            if (poll_r) begin
              scs     <= 1'b1;
              state_r <= ST_POLL;
            end else begin
              done    <= 1'b1;
              state_r <= ST_FIN;
              if (rd_r) begin
                dout <= rx_r;
              end
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_POLL: begin
          // sdo still carries the tail of the frame for the first two cycles
          if ((cnt_r >= POLL_SKIP) && sdo) begin
            cnt_r   <= {CW{1'b0}};
            scs     <= 1'b0;
            state_r <= ST_DESEL2;
          end else if (cnt_r == POLL_LAST) begin
            cnt_r   <= {CW{1'b0}};
            scs     <= 1'b0;
            err     <= 1'b1;
            state_r <= ST_DESEL2;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_DESEL2: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r   <= {CW{1'b0}};
            done    <= 1'b1;
            state_r <= ST_FIN;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          sclk    <= 1'b0;
          scs     <= 1'b0;
          sdi     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt9346_host.sv
// Bench for jt9346_host: a behavioural 93C46 decodes whole frames from the pins,
// and a word-level reference memory predicts every read, latency and error flag.
module tb_jt9346_host;

  localparam int AW       = 6;
  localparam int DW       = 16;
  localparam int CLKDIV   = 4;
  localparam int POLL_MAX = 4096;
  localparam int H        = 3 + AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [2:0]    cmd;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          busy, done, err, sclk, scs, sdi, sdo;
  logic [DW-1:0] dout;

  jt9346_host #(.AW(AW), .DW(DW), .CLKDIV(CLKDIV), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .din(din),
    .busy(busy), .done(done), .err(err), .dout(dout),
    .sclk(sclk), .scs(scs), .sdi(sdi), .sdo(sdo)
  );

  always #5 clk = ~clk;

  // EEPROM model state
  bit          fbits[$];
  bit          last_bits[$];
  int          nb = 0;
  logic        rd_bit = 1'b0;
  int          prog_cnt = 0;
  bit          ew = 1'b0;
  logic [15:0] emem [64];
  logic        sclk_q = 1'b0, scs_q = 1'b0;
  int          frames = 0;
  bit          tie0 = 1'b0;

  assign sdo = tie0 ? 1'b0 : ((nb != 0) ? rd_bit : (prog_cnt == 0));

  // Behavioural 93C46: collects bits at sclk rises, acts on the frame when scs drops.
  always @(posedge clk) begin
    automatic int          n = 0;
    automatic logic [5:0]  a = 6'd0;
    automatic logic [15:0] d = 16'd0;
    automatic bit          prog = 1'b0;
    if (scs && sclk && !sclk_q) begin
      fbits.push_back(sdi);
      n = fbits.size();
      nb <= n;
      if (n >= H && fbits[0] && fbits[1] && !fbits[2]) begin
        for (int i = 0; i < AW; i++) a[AW-1-i] = fbits[3+i];
        if (n == H) rd_bit <= 1'b0;
        else if (n <= H + DW) rd_bit <= emem[a][H+DW-n];
      end
    end
    if (!scs && scs_q && fbits.size() != 0) begin
      n = fbits.size();
      if (n >= H && fbits[0]) begin
        for (int i = 0; i < AW; i++) a[AW-1-i] = fbits[3+i];
        if (n >= H + DW) for (int i = 0; i < DW; i++) d[DW-1-i] = fbits[H+i];
        case ({fbits[1], fbits[2]})
          2'b01: if (ew && n == H + DW) begin emem[a] = d; prog = 1'b1; end
          2'b11: if (ew && n == H) begin emem[a] = 16'hFFFF; prog = 1'b1; end
          2'b00: begin
            case ({fbits[3], fbits[4]})
              2'b11: if (n == H) ew = 1'b1;
              2'b00: if (n == H) ew = 1'b0;
              2'b10: if (ew && n == H) begin
                for (int i = 0; i < 64; i++) emem[i] = 16'hFFFF;
                prog = 1'b1;
              end
              2'b01: if (ew && n == H + DW) begin
                for (int i = 0; i < 64; i++) emem[i] = d;
                prog = 1'b1;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      last_bits = fbits;
      frames++;
      fbits.delete();
      nb <= 0;
    end
    if (prog) prog_cnt <= $urandom_range(40, 3);
    else if (prog_cnt > 0) prog_cnt <= prog_cnt - 1;
    sclk_q <= sclk;
    scs_q  <= scs;
  end

  // Word-level reference
  logic [15:0] ref_mem [64];
  bit          ref_ew;
  int          vectors = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_polled(input logic [2:0] c);
    return (c == 3'd1) || (c == 3'd2) || (c == 3'd5) || (c == 3'd6);
  endfunction

  function automatic int base_lat(input logic [2:0] c);
    int nbits;
    nbits = ((c == 3'd0) || (c == 3'd1) || (c == 3'd6)) ? H + DW : H;
    return 1 + CLKDIV + nbits * 2 * CLKDIV + CLKDIV + 1;
  endfunction

  task automatic ref_apply(input logic [2:0] c, input logic [5:0] a, input logic [15:0] d);
    case (c)
      3'd1: if (ref_ew) ref_mem[a] = d;
      3'd2: if (ref_ew) ref_mem[a] = 16'hFFFF;
      3'd3: ref_ew = 1'b1;
      3'd5: if (ref_ew) for (int i = 0; i < 64; i++) ref_mem[i] = 16'hFFFF;
      3'd6: if (ref_ew) for (int i = 0; i < 64; i++) ref_mem[i] = d;
      3'd4, 3'd7: ref_ew = 1'b0;
      default: ;
    endcase
  endtask

  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (done !== 1'b1 && lat < 6000) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", done, 1'b1);
  endtask

  // Issue one command from an idle negedge; returns at the negedge of the done cycle.
  task automatic issue(input logic [2:0] c, input logic [5:0] a, input logic [15:0] d,
                       input bit chk_lat, output int lat);
    logic [15:0] dprev;
    int b;
    dprev = dout;
    cmd = c; addr = a; din = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("busy_after_req", busy, 1'b1);
    check("err_cleared", err, 1'b0);
    wait_done(2, lat);
    ref_apply(c, a, d);
    b = base_lat(c);
    if (chk_lat) begin
      if (is_polled(c)) check("poll_lat_range", (lat >= b + CLKDIV + 3) && (lat <= b + CLKDIV + 60), 1'b1);
      else check("lat", lat, b);
    end
    if (c == 3'd0) check("read_dout", dout, ref_mem[a]);
    else check("dout_held", dout, dprev);
  endtask

  task automatic idle();
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_done", done, 1'b0);
  endtask

  task automatic read_check(input logic [5:0] a);
    int lat;
    issue(3'd0, a, 16'h0000, 1'b1, lat);
    check("read_lat_210", lat, 210);
    check("read_err", err, 1'b0);
    idle();
  endtask

  initial begin
    int lat, w, f0, bh;
    logic [8:0] hb;
    logic [2:0] rc;
    rst = 1'b1; req = 1'b0; cmd = 3'd0; addr = '0; din = '0; ref_ew = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_dout", dout, 16'h0000);
    check("rst_pins", {sclk, scs, sdi}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    // EWEN frame and latency
    issue(3'd3, 6'd0, 16'd0, 1'b1, lat);
    check("ewen_lat_82", lat, 82);
    check("ewen_err", err, 1'b0);
    check("ewen_len", last_bits.size(), H);
    for (int i = 0; i < 9; i++) hb[8-i] = last_bits[i];
    check("ewen_bits", hb, 9'b100110000);
    idle();

    issue(3'd5, 6'd0, 16'd0, 1'b1, lat);
    check("eral_err", err, 1'b0);
    idle();

    // WRITE then READ back
    issue(3'd1, 6'h15, 16'hA5C3, 1'b1, lat);
    check("write_err", err, 1'b0);
    check("write_len", last_bits.size(), H + DW);
    check("write_bit0", last_bits[H], 1'b1);
    idle();
    read_check(6'h15);

    issue(3'd2, 6'h15, 16'd0, 1'b1, lat);
    idle();
    read_check(6'h15);
    issue(3'd6, 6'd0, 16'h1234, 1'b1, lat);
    idle();
    read_check(6'h00);
    read_check(6'h3F);

    // cmd 7 disables writes like EWDS
    issue(3'd7, 6'd0, 16'd0, 1'b1, lat);
    idle();
    issue(3'd1, 6'h15, 16'h5555, 1'b1, lat);
    idle();
    read_check(6'h15);
    issue(3'd3, 6'd0, 16'd0, 1'b1, lat);
    idle();

    // randomized command mix over a small address window
    for (int k = 0; k < 14; k++) begin
      rc = 3'($urandom_range(7, 0));
      issue(rc, 6'($urandom_range(3, 0)), 16'($urandom), 1'b1, lat);
      check("rand_err", err, 1'b0);
      idle();
    end
    issue(3'd3, 6'd0, 16'd0, 1'b1, lat);
    idle();
    for (int k = 0; k < 4; k++) read_check(6'(k));

    // poll timeout with sdo stuck low
    tie0 = 1'b1;
    issue(3'd1, 6'h2A, 16'h0F0F, 1'b0, lat);
    check("timeout_lat", lat, base_lat(3'd1) + POLL_MAX + CLKDIV);
    check("timeout_err", err, 1'b1);
    check("timeout_scs", scs, 1'b0);
    idle();
    check("timeout_err_held", err, 1'b1);
    tie0 = 1'b0;
    issue(3'd3, 6'd0, 16'd0, 1'b1, lat);
    check("err_cleared_done", err, 1'b0);
    idle();
    read_check(6'h2A);

    // reset during the 5th header bit of a READ
    cmd = 3'd0; addr = 6'h2A; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    w = 0;
    while (nb < 5 && w < 200) begin @(negedge clk); w++; end
    check("reach_bit5", nb, 5);
    rst = 1'b1;
    #1;
    check("midrst_pins", {sclk, scs, sdi}, 3'b000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_dout", dout, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    read_check(6'h2A);

    // req pulsed while busy is ignored
    f0 = frames;
    cmd = 3'd3; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (20) @(negedge clk);
    cmd = 3'd1; addr = 6'h01; din = 16'hDEAD; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done(0, lat);
    bh = 0;
    repeat (10) begin @(negedge clk); if (busy) bh++; end
    check("pulse_no_restart", bh, 0);
    check("pulse_frames", frames - f0, 1);

    // held req: one frame per acceptance, restart the cycle after busy falls
    f0 = frames;
    cmd = 3'd3; req = 1'b1;
    @(negedge clk);
    wait_done(0, lat);
    @(negedge clk);
    check("held_gap_busy", busy, 1'b0);
    check("held_gap_done", done, 1'b0);
    @(negedge clk);
    check("held_restart", busy, 1'b1);
    req = 1'b0;
    wait_done(0, lat);
    bh = 0;
    repeat (10) begin @(negedge clk); if (busy) bh++; end
    check("held_stop", bh, 0);
    check("held_frames", frames - f0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
